// File: rtl/loop_ctrl_pkg.sv
// Shared widths and FSM encoding for the nested-loop sequencer.
package loop_ctrl_pkg;

  localparam int unsigned LOOP_ID_W   = 5;
  localparam int unsigned LOOP_ITER_W = 16;
  localparam int unsigned MAX_LOOPS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/loop_level_counter.sv
// One loop level: iteration limit, current count, and carry to the next-outer level.
module loop_level_counter #(
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ITER_W-1:0] wr_data,
  input  logic              carry_in,
  output logic              carry_out
);

  logic [ITER_W-1:0] cnt_q;
  logic [ITER_W-1:0] limit_q;
  logic              at_limit;

  assign at_limit  = (cnt_q == limit_q);
  assign carry_out = carry_in && at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else if (flush) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      if (wr_en) limit_q <= wr_data;
      if (clear) cnt_q <= '0;
      else if (carry_in) cnt_q <= at_limit ? '0 : cnt_q + ITER_W'(1);
    end
  end

endmodule

// File: rtl/loop_nest_ctrl.sv
// Nested-loop sequencer: captures per-level counts from the decoder, then
// walks the nest one iteration per non-stalled cycle.
module loop_nest_ctrl #(
  parameter int unsigned LOOP_ID_W   = loop_ctrl_pkg::LOOP_ID_W,
  parameter int unsigned LOOP_ITER_W = loop_ctrl_pkg::LOOP_ITER_W,
  parameter int unsigned MAX_LOOPS   = loop_ctrl_pkg::MAX_LOOPS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  input  logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id,
  input  logic                   loop_ctrl_start,
  input  logic                   stall,
  output logic                   loop_ctrl_done,
  output logic                   busy,
  output logic                   iter_v,
  output logic [LOOP_ID_W-1:0]   iter_level,
  output logic                   iter_first,
  output logic                   iter_last,
  output logic                   cfg_err
);
  import loop_ctrl_pkg::*;

  localparam int unsigned DEPTH_W = $clog2(MAX_LOOPS + 1);
  localparam int unsigned LVL_W   = $clog2(MAX_LOOPS);
  localparam logic [LOOP_ID_W:0] MAX_ID = (LOOP_ID_W + 1)'(MAX_LOOPS);

  state_e               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_eff, cfg_depth;
  logic                 first_q;
  logic [LOOP_ID_W-1:0] lvl_q, step_lvl;
  logic                 cfg_ok, cfg_bad, start_run, flush, step;
  logic [MAX_LOOPS-1:0] cin_vec;

  // Writes land only in IDLE and only for physical levels.
  assign cfg_ok    = cfg_loop_iter_v && (state_q == ST_IDLE) &&
                     ({1'b0, cfg_loop_iter_loop_id} < MAX_ID);
  assign cfg_bad   = cfg_loop_iter_v && !cfg_ok;
  assign cfg_depth = DEPTH_W'(cfg_loop_iter_loop_id) + DEPTH_W'(1);
  assign depth_eff = (cfg_ok && (cfg_depth > depth_q)) ? cfg_depth : depth_q;

  assign step       = (state_q == ST_RUN) && !stall;
  assign iter_v     = step;
  assign iter_first = step && first_q;
  assign iter_level = (step && !first_q) ? lvl_q : '0;

  // Carry enters at the innermost active level and ripples outward.
  for (genvar l = 0; l < MAX_LOOPS; l++) begin : g_lvl
    logic cin, cout, nxt;
    if (l == MAX_LOOPS - 1) begin : g_outer
      assign nxt = 1'b0;
    end else begin : g_inner
      assign nxt = g_lvl[l+1].cout;
    end
    assign cin = (depth_q == DEPTH_W'(l + 1)) ? step :
                 ((depth_q > DEPTH_W'(l + 1)) ? nxt : 1'b0);
    assign cin_vec[l] = cin;

    loop_level_counter #(.ITER_W(LOOP_ITER_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_run),
      .flush     (flush),
      .wr_en     (cfg_ok && (cfg_loop_iter_loop_id == LOOP_ID_W'(l))),
      .wr_data   (cfg_loop_iter),
      .carry_in  (cin),
      .carry_out (cout)
    );
  end

  // Carry out of level 0 means every active level is at its limit on this issue.
  assign iter_last = g_lvl[0].cout;

  // Outermost level touched by this step; shown on the following issue.
  always_comb begin
    step_lvl = '0;
    for (int l = MAX_LOOPS - 1; l >= 0; l--) begin
      if (cin_vec[LVL_W'(l)]) step_lvl = LOOP_ID_W'(l);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    flush     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (loop_ctrl_start) begin
          if (depth_eff == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RUN;
            start_run = 1'b1;
          end
        end
      end
      ST_RUN:  if (iter_last) state_d = ST_DONE;
      ST_DONE: begin
        flush   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q        <= '0;
      first_q        <= 1'b0;
      lvl_q          <= '0;
      cfg_err        <= 1'b0;
      busy           <= 1'b0;
      loop_ctrl_done <= 1'b0;
    end else begin
      cfg_err        <= cfg_err | cfg_bad;
      busy           <= (state_d == ST_RUN);
      loop_ctrl_done <= (state_d == ST_DONE);
      depth_q        <= flush ? '0 : depth_eff;
      if (start_run) first_q <= 1'b1;
      else if (step) first_q <= 1'b0;
      if (step) lvl_q <= step_lvl;
    end
  end

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Scoreboard bench for loop_nest_ctrl: an odometer model predicts each issued
// iteration and the done pulse; a negedge monitor pops and compares.
module tb_loop_nest_ctrl;

  localparam int unsigned IDW = 5;
  localparam int unsigned ITW = 16;
  localparam int          ML  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_loop_iter_v;
  logic [ITW-1:0] cfg_loop_iter;
  logic [IDW-1:0] cfg_loop_iter_loop_id;
  logic           loop_ctrl_start;
  logic           stall;
  logic           loop_ctrl_done;
  logic           busy;
  logic           iter_v;
  logic [IDW-1:0] iter_level;
  logic           iter_first;
  logic           iter_last;
  logic           cfg_err;

  loop_nest_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .cfg_loop_iter_v       (cfg_loop_iter_v),
    .cfg_loop_iter         (cfg_loop_iter),
    .cfg_loop_iter_loop_id (cfg_loop_iter_loop_id),
    .loop_ctrl_start       (loop_ctrl_start),
    .stall                 (stall),
    .loop_ctrl_done        (loop_ctrl_done),
    .busy                  (busy),
    .iter_v                (iter_v),
    .iter_level            (iter_level),
    .iter_first            (iter_first),
    .iter_last             (iter_last),
    .cfg_err               (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit done;
    int level;
    bit first;
    bit last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   lim_m[ML];
  int   depth_m = 0;
  bit   mon_en = 1'b0;
  int   iter_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every iteration or done pulse must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall && busy) check("stall_blocks_iter", iter_v, 0);
      if (iter_v || loop_ctrl_done) begin
        if (q.size() == 0) begin
          check("unexpected_output", {iter_v, loop_ctrl_done}, 0);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.done) begin
            check("done_pulse", loop_ctrl_done, 1);
            check("done_without_iter", iter_v, 0);
          end else begin
            iter_cnt++;
            check("iter_v", iter_v, 1);
            check("iter_level", iter_level, mon_e.level);
            check("iter_first", iter_first, mon_e.first);
            check("iter_last", iter_last, mon_e.last);
            check("busy_in_run", busy, 1);
          end
        end
      end
    end
  end

  task automatic model_clear();
    foreach (lim_m[i]) lim_m[i] = 0;
    depth_m = 0;
  endtask

  task automatic model_write(input int id, input int val);
    if (id < ML) begin
      lim_m[id] = val;
      if (id + 1 > depth_m) depth_m = id + 1;
    end
  endtask

  // Called at posedge+1; the write occupies exactly one cycle.
  task automatic cfg_write(input int id, input int val);
    cfg_loop_iter_v       = 1'b1;
    cfg_loop_iter_loop_id = IDW'(id);
    cfg_loop_iter         = ITW'(val);
    model_write(id, val);
    @(posedge clk); #1;
    cfg_loop_iter_v = 1'b0;
  endtask

  // Mixed-radix odometer, level depth-1 least significant.
  task automatic push_block(output int n_iter);
    int dig[ML];
    int prv[ML];
    int tot, r, lvl;
    tot = (depth_m == 0) ? 0 : 1;
    for (int l = 0; l < depth_m; l++) tot = tot * (lim_m[l] + 1);
    foreach (prv[i]) prv[i] = 0;
    for (int n = 0; n < tot; n++) begin
      r = n;
      for (int l = depth_m - 1; l >= 0; l--) begin
        dig[l] = r % (lim_m[l] + 1);
        r = r / (lim_m[l] + 1);
      end
      lvl = 0;
      if (n > 0)
        for (int l = depth_m - 1; l >= 0; l--) if (dig[l] != prv[l]) lvl = l;
      q.push_back('{done: 1'b0, level: lvl, first: (n == 0), last: (n == tot - 1)});
      prv = dig;
    end
    q.push_back('{done: 1'b1, level: 0, first: 1'b0, last: 1'b0});
    n_iter = tot;
    model_clear();
  endtask

  function automatic logic stall_at(input int mode, input int k);
    case (mode)
      1:       return (k >= 2 && k <= 4);
      2:       return ($urandom_range(0, 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_block(input int stall_mode, input bit cfg_in_run,
                           input bit cfg_with_start, input int cs_id, input int cs_val);
    int n_exp, k;
    if (cfg_with_start) begin
      cfg_loop_iter_v       = 1'b1;
      cfg_loop_iter_loop_id = IDW'(cs_id);
      cfg_loop_iter         = ITW'(cs_val);
      model_write(cs_id, cs_val);
    end
    push_block(n_exp);
    iter_cnt = 0;
    loop_ctrl_start = 1'b1;
    @(posedge clk); #1;
    loop_ctrl_start = 1'b0;
    cfg_loop_iter_v = 1'b0;
    if (n_exp == 0) check("depth0_done_latency", loop_ctrl_done, 1);
    k = 1;
    stall = stall_at(stall_mode, k);
    while (q.size() != 0 && k < 5000) begin
      @(posedge clk); #1;
      k++;
      stall = stall_at(stall_mode, k);
      if (cfg_in_run) begin
        cfg_loop_iter_v       = (k == 2);
        cfg_loop_iter_loop_id = '0;
        cfg_loop_iter         = ITW'(5);
      end
    end
    stall = 1'b0;
    cfg_loop_iter_v = 1'b0;
    check("queue_drained", q.size(), 0);
    q.delete();
    check("iter_count", iter_cnt, n_exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d;
    reset = 1'b1;
    cfg_loop_iter_v = 1'b0;
    cfg_loop_iter = '0;
    cfg_loop_iter_loop_id = '0;
    loop_ctrl_start = 1'b0;
    stall = 1'b0;
    model_clear();
    #12;
    check("rst_iter_v", iter_v, 0);
    check("rst_busy", busy, 0);
    check("rst_done", loop_ctrl_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_level", iter_level, 0);
    check("rst_first_last", {iter_first, iter_last}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Empty nest: done only.
    run_block(0, 0, 0, 0, 0);

    // Single level, 4 iterations.
    cfg_write(0, 3);
    run_block(0, 0, 0, 0, 0);
    check("cfg_err_clean", cfg_err, 0);

    // Two levels; a write during RUN is dropped and flagged.
    cfg_write(0, 1);
    cfg_write(1, 2);
    run_block(0, 1, 0, 0, 0);
    check("cfg_err_run_write", cfg_err, 1);
    run_block(0, 0, 0, 0, 0);

    // Same nest with stall on RUN cycles 2..4.
    cfg_write(0, 1);
    cfg_write(1, 2);
    run_block(1, 0, 0, 0, 0);

    // Async reset mid-RUN.
    mon_en = 1'b0;
    cfg_write(0, 2);
    cfg_write(1, 3);
    loop_ctrl_start = 1'b1;
    @(posedge clk); #1;
    loop_ctrl_start = 1'b0;
    @(posedge clk); #2;
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    #1;
    check("arst_iter_v", iter_v, 0);
    check("arst_busy", busy, 0);
    check("arst_done", loop_ctrl_done, 0);
    check("arst_flags", {iter_first, iter_last}, 0);
    check("arst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    check("arst_no_done", loop_ctrl_done, 0);
    reset = 1'b0;
    model_clear();
    q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Out-of-range id dropped; write with start uses the new depth.
    cfg_write(9, 4);
    check("cfg_err_bad_id", cfg_err, 1);
    cfg_write(0, 1);
    cfg_write(1, 2);
    run_block(0, 0, 1, 2, 1);

    // Deepest level only: levels 0..6 default to one iteration.
    cfg_write(7, 1);
    run_block(0, 0, 0, 0, 0);
    cfg_write(0, 0);
    run_block(0, 0, 0, 0, 0);
    cfg_write(0, 1);
    cfg_write(1, 299);
    run_block(2, 0, 0, 0, 0);

    repeat (20) begin
      d = $urandom_range(1, 3);
      for (int l = 0; l < d; l++)
        if ($urandom_range(0, 3) != 0) cfg_write(l, $urandom_range(0, 3));
      run_block(2, 0, 0, 0, 0);
    end

    check("cfg_err_sticky", cfg_err, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
